// File: rtl/shift_step_ctrl.sv
// Button conditioning and word-state stage for the barrel shifter: sync, debounce,
// edge-detect, and a small FSM that issues one shifter step per accepted press.
module shift_step_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BTNR,
    input  logic             BTNL,
    input  logic             BTNC,
    input  logic             BTNU,
    input  logic [WIDTH-1:0] sw,
    input  logic [WIDTH-1:0] shout,
    output logic [WIDTH-1:0] data,
    output logic             shift_r,
    output logic             shift_l,
    output logic             shift_c,
    output logic [7:0]       step_count,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a load or a single-direction press
    // APPLY | one cycle: drive shifter controls, capture shout
    // HOLD  | wait until both R and L are debounced low
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam int            IDX_R  = 0;
    localparam int            IDX_L  = 1;
    localparam int            IDX_C  = 2;
    localparam int            IDX_U  = 3;

    logic [3:0]       raw;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       db_q, db_d;
    logic [CW-1:0]    cnt_q [4];
    logic [CW-1:0]    cnt_d [4];
    logic [2:0]       db_rlu;
    logic [2:0]       dly_q;
    logic [2:0]       rise;
    logic             rise_r, rise_l, rise_u;
    logic             db_r, db_l, db_c;

    state_t           state_q, state_d;
    logic             dir_r_q, dir_r_d;
    logic             c_lat_q, c_lat_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       step_q, step_d;

    assign raw = {BTNU, BTNC, BTNL, BTNR};

    // Debouncers: a level only flips after DB_MAX consecutive disagreeing cycles.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign db_r   = db_q[IDX_R];
    assign db_l   = db_q[IDX_L];
    assign db_c   = db_q[IDX_C];
    assign db_rlu = {db_q[IDX_U], db_l, db_r};
    assign rise   = db_rlu & ~dly_q;
    assign rise_r = rise[0];
    assign rise_l = rise[1];
    assign rise_u = rise[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            dly_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            dir_r_q <= 1'b0;
            c_lat_q <= 1'b0;
            data_q  <= '0;
            step_q  <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dly_q   <= db_rlu;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dir_r_q <= dir_r_d;
            c_lat_q <= c_lat_d;
            data_q  <= data_d;
            step_q  <= step_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_r_d = dir_r_q;
        c_lat_d = c_lat_q;
        data_d  = data_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                // Load wins over any simultaneous R/L rise.
                if (rise_u) begin
                    data_d = sw;
                    step_d = '0;
                end else if ((rise_r && !db_l) || (rise_l && !db_r)) begin
                    dir_r_d = rise_r;
                    c_lat_d = db_c;
                    state_d = APPLY;
                end else if (rise_r || rise_l) begin
                    state_d = HOLD;
                end
            end
            APPLY: begin
                data_d  = shout;
                step_d  = step_q + 8'd1;
                state_d = HOLD;
            end
            HOLD: begin
                if (!db_r && !db_l) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_r = 1'b0;
        shift_l = 1'b0;
        shift_c = 1'b0;
        busy    = (state_q != IDLE);
        if (state_q == APPLY) begin
            shift_r = dir_r_q;
            shift_l = !dir_r_q;
            shift_c = c_lat_q;
        end
    end

    assign data       = data_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_shift_step_ctrl.sv
// Directed bench for shift_step_ctrl with a combinational rotate model standing in
// for the barrel shifter (1-bit rotate, 2-bit when shift_c is set).
module tb_shift_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        BTNR = 1'b0, BTNL = 1'b0, BTNC = 1'b0, BTNU = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic [15:0] shout;
    logic [15:0] data;
    logic        shift_r, shift_l, shift_c;
    logic [7:0]  step_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int nr, nl, nc, nlc;
    logic found;

    shift_step_ctrl #(.WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .BTNR(BTNR), .BTNL(BTNL), .BTNC(BTNC), .BTNU(BTNU),
        .sw(sw), .shout(shout), .data(data),
        .shift_r(shift_r), .shift_l(shift_l), .shift_c(shift_c),
        .step_count(step_count), .busy(busy)
    );

    function automatic logic [15:0] rot(input logic [15:0] d, input logic r, input logic l,
                                        input logic c);
        if (r) return c ? {d[1:0], d[15:2]} : {d[0], d[15:1]};
        if (l) return c ? {d[13:0], d[15:14]} : {d[14:0], d[15]};
        return d;
    endfunction

    assign shout = rot(data, shift_r, shift_l, shift_c);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_count(input int n);
        nr = 0; nl = 0; nc = 0; nlc = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            nr  += int'(shift_r);
            nl  += int'(shift_l);
            nc  += int'(shift_c);
            nlc += int'(shift_l & shift_c);
        end
    endtask

    initial begin
        // reset
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_data", 32'(data), 32'h0000);
        chk("rst_step", 32'(step_count), 32'd0);
        chk("rst_shift", 32'({shift_r, shift_l, shift_c}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // load 8001: data changes on the 8th edge after BTNU is first sampled
        sw   = 16'h8001;
        BTNU = 1'b1;
        repeat (7) tick();
        chk("load_early", 32'(data), 32'h0000);
        tick();
        chk("load_data", 32'(data), 32'h8001);
        chk("load_step", 32'(step_count), 32'd0);
        chk("load_busy", 32'(busy), 32'd0);
        repeat (4) tick();
        BTNU = 1'b0;
        repeat (10) tick();

        // long right press -> exactly one rotate
        BTNR = 1'b1;
        run_count(50);
        chk("r_pulses", 32'(nr), 32'd1);
        chk("r_no_l", 32'(nl), 32'd0);
        chk("r_no_c", 32'(nc), 32'd0);
        chk("r_data", 32'(data), 32'hC000);
        chk("r_step", 32'(step_count), 32'd1);
        chk("r_busy_held", 32'(busy), 32'd1);
        BTNR = 1'b0;
        repeat (3) tick();
        chk("r_busy_release", 32'(busy), 32'd1);
        repeat (10) tick();
        chk("r_busy_idle", 32'(busy), 32'd0);

        // reload, then BTNC + BTNL -> double left step
        BTNU = 1'b1;
        repeat (10) tick();
        BTNU = 1'b0;
        repeat (10) tick();
        chk("reload_data", 32'(data), 32'h8001);
        chk("reload_step", 32'(step_count), 32'd0);
        BTNC = 1'b1;
        repeat (10) tick();
        chk("c_alone_busy", 32'(busy), 32'd0);
        BTNL = 1'b1;
        run_count(30);
        chk("lc_l_pulses", 32'(nl), 32'd1);
        chk("lc_both", 32'(nlc), 32'd1);
        chk("lc_no_r", 32'(nr), 32'd0);
        chk("lc_data", 32'(data), 32'h0006);
        chk("lc_step", 32'(step_count), 32'd1);
        BTNC = 1'b0;
        run_count(20);
        chk("c_rel_pulses", 32'(nl + nr), 32'd0);
        chk("c_rel_data", 32'(data), 32'h0006);
        chk("c_rel_busy", 32'(busy), 32'd1);
        BTNL = 1'b0;
        repeat (10) tick();
        chk("l_rel_busy", 32'(busy), 32'd0);

        // bouncing BTNR never settles
        nr = 0;
        for (int i = 0; i < 15; i++) begin
            BTNR = ~BTNR;
            repeat (2) begin
                tick();
                nr += int'(shift_r);
            end
        end
        BTNR = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nr += int'(shift_r);
        end
        chk("bounce_pulses", 32'(nr), 32'd0);
        chk("bounce_data", 32'(data), 32'h0006);
        chk("bounce_busy", 32'(busy), 32'd0);

        // R and L together -> HOLD, no shift
        BTNR = 1'b1;
        BTNL = 1'b1;
        run_count(20);
        chk("rl_pulses", 32'(nr + nl), 32'd0);
        chk("rl_busy", 32'(busy), 32'd1);
        chk("rl_data", 32'(data), 32'h0006);
        BTNR = 1'b0;
        BTNL = 1'b0;
        repeat (10) tick();
        chk("rl_idle", 32'(busy), 32'd0);

        // separate R press after the conflict
        BTNR = 1'b1;
        run_count(20);
        chk("r2_pulses", 32'(nr), 32'd1);
        chk("r2_data", 32'(data), 32'h0003);
        chk("r2_step", 32'(step_count), 32'd2);
        BTNR = 1'b0;
        repeat (10) tick();

        // reset landing on the APPLY cycle: no commit
        BTNR  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (shift_r) found = 1'b1;
        end
        chk("apply_seen", 32'(found), 32'd1);
        rst  = 1'b1;
        BTNR = 1'b0;
        tick();
        chk("mid_rst_data", 32'(data), 32'h0000);
        chk("mid_rst_step", 32'(step_count), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        chk("mid_rst_shift", 32'({shift_r, shift_l, shift_c}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        run_count(10);
        chk("post_rst_pulses", 32'(nr + nl), 32'd0);
        chk("post_rst_data", 32'(data), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
